// File: rtl/fir_tap_delay_line_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared constants and width helpers for the symmetric FIR tap delay line.
//   DEFAULT_WIDTH : default sample width (signed two's complement)
//   DEFAULT_DEPTH : default number of taps (odd)
//   sum_width()   : width of one symmetric pre-add sum (one growth bit)
//   fill_width()  : width of the saturating fill counter (0..DEPTH)
// ---------------------------------------------------------------------------
package fir_pkg;

  localparam int DEFAULT_WIDTH = 10;
  localparam int DEFAULT_DEPTH = 5;

  // Adding two WIDTH-bit signed values needs exactly one extra bit.
  function automatic int sum_width(input int width);
    return width + 1;
  endfunction

  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fir_tap_delay_line_if.sv
// ---------------------------------------------------------------------------
// fir_tap_delay_line_if
// Groups the sample input, flush control and all tap/sum outputs of the
// delay line.
//   master : drives in_valid, in_data, flush; observes the outputs
//   slave  : the delay line itself
// Signals:
//   in_valid / in_data   sample strobe and signed sample
//   flush                synchronous clear of taps and fill count
//   taps                 DEPTH*WIDTH flattened taps, tap[0] (newest) at LSBs
//   fill_count / full    samples held since reset/flush, full when == DEPTH
//   pair_sum             (DEPTH/2)*(WIDTH+1) registered symmetric sums
//   centre / out_valid   registered centre tap and full-line result pulse
// ---------------------------------------------------------------------------
interface fir_tap_delay_line_if
  import fir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) ();

  localparam int SW = sum_width(WIDTH);
  localparam int FW = fill_width(DEPTH);
  localparam int NP = DEPTH / 2;

  logic                      in_valid;
  logic signed [WIDTH-1:0]   in_data;
  logic                      flush;
  logic [DEPTH*WIDTH-1:0]    taps;
  logic [FW-1:0]             fill_count;
  logic                      full;
  logic [NP*SW-1:0]          pair_sum;
  logic signed [WIDTH-1:0]   centre;
  logic                      out_valid;

  modport master (
    output in_valid, in_data, flush,
    input  taps, fill_count, full, pair_sum, centre, out_valid
  );

  modport slave (
    input  in_valid, in_data, flush,
    output taps, fill_count, full, pair_sum, centre, out_valid
  );

endinterface

// File: rtl/fir_tap_delay_line_tap_reg.sv
// ---------------------------------------------------------------------------
// fir_tap_reg
// One signed WIDTH-bit tap register.
//   clk   : rising-edge clock
//   rst   : synchronous reset, active-low (highest priority)
//   i_clr : synchronous clear (beats i_en)
//   i_en  : load i_d
//   i_d   : next sample value
//   o_q   : registered tap value
// ---------------------------------------------------------------------------
module fir_tap_reg #(
  parameter int WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [WIDTH-1:0] i_d,
  output logic signed [WIDTH-1:0] o_q
);

  logic signed [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fir_tap_delay_line.sv
// ---------------------------------------------------------------------------
// fir_tap_delay_line
// Enable-gated tap delay line with fill tracking and a registered symmetric
// pre-add stage for a symmetric FIR.
//   clk : rising-edge clock
//   rst : synchronous reset, active-low
//   bus : fir_tap_delay_line_if.slave (samples in, taps/sums/valid out)
// Results: pair_sum[i] = tap[i] + tap[DEPTH-1-i] and centre = tap[DEPTH/2]
// are registered one cycle after each shift; out_valid pulses only when the
// line was full after that shift.
// ---------------------------------------------------------------------------
module fir_tap_delay_line
  import fir_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic                 clk,
  input logic                 rst,
  fir_tap_delay_line_if.slave bus
);

  localparam int SW = sum_width(WIDTH);
  localparam int FW = fill_width(DEPTH);
  localparam int NP = DEPTH / 2;

  logic signed [WIDTH-1:0] w_taps [DEPTH];
  logic [FW-1:0]           r_fill_count;
  logic                    w_full;
  logic                    r_shifted;
  logic                    r_out_valid;
  logic signed [WIDTH-1:0] r_centre;
  logic signed [SW-1:0]    r_pair_sum [NP];

  // Tap chain. A flush clears every tap, except that tap[0] still loads a
  // sample arriving in the same cycle (clear-then-load).
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tap
      logic signed [WIDTH-1:0] w_d;
      logic                    w_clr;
      if (gi == 0) begin : g_head
        assign w_d   = bus.in_data;
        assign w_clr = bus.flush & ~bus.in_valid;
      end else begin : g_body
        assign w_d   = w_taps[gi-1];
        assign w_clr = bus.flush;
      end
      fir_tap_reg #(.WIDTH(WIDTH)) u_tap (
        .clk   (clk),
        .rst   (rst),
        .i_en  (bus.in_valid),
        .i_clr (w_clr),
        .i_d   (w_d),
        .o_q   (w_taps[gi])
      );
      assign bus.taps[gi*WIDTH +: WIDTH] = w_taps[gi];
    end
  endgenerate

  assign w_full = (r_fill_count == FW'(DEPTH));

  // Fill counter, shift tracking and the centre/valid part of the pre-add
  // stage. r_shifted marks that the taps changed on the previous edge
  // (a flush-with-load counts, but can never report full).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fill_count <= '0;
      r_shifted    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_centre     <= '0;
    end else begin
      if (bus.flush) begin
        r_fill_count <= bus.in_valid ? FW'(1) : '0;
      end else if (bus.in_valid && !w_full) begin
        r_fill_count <= r_fill_count + FW'(1);
      end
      r_shifted <= bus.in_valid;
      if (r_shifted) begin
        r_centre <= w_taps[NP];
      end
      // A flush empties the line, so any pulse due now is cancelled.
      r_out_valid <= r_shifted & w_full & ~bus.flush;
    end
  end

  // Symmetric pre-add; operands are sign-extended so the sum cannot wrap.
  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_pair
      logic signed [SW-1:0] w_a;
      logic signed [SW-1:0] w_b;
      assign w_a = {w_taps[gi][WIDTH-1], w_taps[gi]};
      assign w_b = {w_taps[DEPTH-1-gi][WIDTH-1], w_taps[DEPTH-1-gi]};
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_pair_sum[gi] <= '0;
        end else if (r_shifted) begin
          r_pair_sum[gi] <= w_a + w_b;
        end
      end
      assign bus.pair_sum[gi*SW +: SW] = r_pair_sum[gi];
    end
  endgenerate

  assign bus.fill_count = r_fill_count;
  assign bus.full       = w_full;
  assign bus.centre     = r_centre;
  assign bus.out_valid  = r_out_valid;

endmodule

// File: tb/tb_fir_tap_delay_line.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_delay_line
// Directed bench for fir_tap_delay_line with WIDTH=10, DEPTH=5. Inputs are
// driven 1 time unit after a rising edge; outputs are checked there too,
// i.e. after the edge that consumed the previous inputs.
// ---------------------------------------------------------------------------
module tb_fir_tap_delay_line;

  localparam int W = 10;
  localparam int D = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fir_tap_delay_line_if #(.WIDTH(W), .DEPTH(D)) bus ();

  fir_tap_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic signed [W-1:0] tap(input int i);
    return bus.taps[i*W +: W];
  endfunction

  function automatic logic signed [W:0] ps(input int i);
    return bus.pair_sum[i*(W+1) +: (W+1)];
  endfunction

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs and advance past the consuming edge.
  task automatic drive(input logic v, input logic signed [W-1:0] d,
                       input logic f);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.flush    = f;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_taps"}, 64'(bus.taps), 0);
    check({tag, "_ps0"}, ps(0), 0);
    check({tag, "_ps1"}, ps(1), 0);
    check({tag, "_centre"}, bus.centre, 0);
    check({tag, "_fill"}, 64'(bus.fill_count), 0);
    check({tag, "_full"}, 64'(bus.full), 0);
    check({tag, "_ovalid"}, 64'(bus.out_valid), 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    #1;

    // Reset held for 3 cycles with samples presented.
    rst = 1'b0;
    drive(1'b1, 10'sd100, 1'b0);
    drive(1'b1, 10'sd101, 1'b1);
    drive(1'b1, 10'sd102, 1'b0);
    check_zero_state("reset");
    rst = 1'b1;

    // Fill with 1..5.
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 10'(k), 1'b0);
      check($sformatf("fill_tap0_%0d", k), tap(0), k);
      check($sformatf("fill_count_%0d", k), 64'(bus.fill_count), k);
      check($sformatf("fill_ovalid_%0d", k), 64'(bus.out_valid), 0);
    end
    check("fill_full", 64'(bus.full), 1);
    check("fill_tap4", tap(4), 1);
    drive(1'b0, 10'sd0, 1'b0);
    check("fill_ps0", ps(0), 6);
    check("fill_ps1", ps(1), 6);
    check("fill_centre", bus.centre, 3);
    check("fill_ovalid", 64'(bus.out_valid), 1);
    drive(1'b0, 10'sd0, 1'b0);
    check("fill_ovalid_pulse", 64'(bus.out_valid), 0);
    check("fill_ps0_hold", ps(0), 6);

    // Extremes: all -512, then all 511, then mixed.
    for (int k = 0; k < 5; k++) drive(1'b1, -10'sd512, 1'b0);
    check("ext_b2b_ovalid", 64'(bus.out_valid), 1);
    check("ext_fill_sat", 64'(bus.fill_count), 5);
    drive(1'b0, 10'sd0, 1'b0);
    check("ext_neg_ps0", ps(0), -1024);
    check("ext_neg_ps1", ps(1), -1024);
    check("ext_neg_centre", bus.centre, -512);
    for (int k = 0; k < 5; k++) drive(1'b1, 10'sd511, 1'b0);
    drive(1'b0, 10'sd0, 1'b0);
    check("ext_pos_ps0", ps(0), 1022);
    check("ext_pos_centre", bus.centre, 511);
    drive(1'b1, -10'sd512, 1'b0);
    drive(1'b1, -10'sd512, 1'b0);
    drive(1'b0, 10'sd0, 1'b0);
    check("ext_mix_ps0", ps(0), -1);
    check("ext_mix_ps1", ps(1), -1);
    check("ext_mix_centre", bus.centre, 511);

    // Gaps: line is [-512,-512,511,511,511]; in_valid 1,0,0,1 then idle.
    drive(1'b1, 10'sd10, 1'b0);
    check("gap_a_tap0", tap(0), 10);
    check("gap_a_ovalid", 64'(bus.out_valid), 0);
    drive(1'b0, 10'sd55, 1'b0);
    check("gap_b_ovalid", 64'(bus.out_valid), 1);
    check("gap_b_ps0", ps(0), 521);
    check("gap_b_ps1", ps(1), -1);
    check("gap_b_centre", bus.centre, -512);
    drive(1'b0, 10'sd66, 1'b0);
    check("gap_c_ovalid", 64'(bus.out_valid), 0);
    check("gap_c_tap0", tap(0), 10);
    check("gap_c_ps0", ps(0), 521);
    drive(1'b1, 10'sd20, 1'b0);
    check("gap_d_ovalid", 64'(bus.out_valid), 0);
    check("gap_d_ps0", ps(0), 521);
    drive(1'b0, 10'sd0, 1'b0);
    check("gap_e_ovalid", 64'(bus.out_valid), 1);
    check("gap_e_ps0", ps(0), 531);
    check("gap_e_ps1", ps(1), -502);

    // Flush with a sample on a full line.
    drive(1'b1, 10'sd7, 1'b1);
    check("flush_taps", 64'(bus.taps), 7);
    check("flush_fill", 64'(bus.fill_count), 1);
    check("flush_full", 64'(bus.full), 0);
    check("flush_ovalid", 64'(bus.out_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 10'(k), 1'b0);
      check($sformatf("postflush_ovalid_%0d", k), 64'(bus.out_valid), 0);
    end
    check("postflush_full", 64'(bus.full), 1);
    drive(1'b0, 10'sd0, 1'b0);
    check("postflush_first_ovalid", 64'(bus.out_valid), 1);
    check("postflush_ps0", ps(0), 11);
    check("postflush_ps1", ps(1), 4);
    check("postflush_centre", bus.centre, 2);

    // Reset mid-stream after 3 samples on a full line.
    drive(1'b1, 10'sd9, 1'b0);
    drive(1'b1, 10'sd8, 1'b0);
    drive(1'b1, 10'sd7, 1'b0);
    rst = 1'b0;
    drive(1'b1, 10'sd6, 1'b0);
    check_zero_state("midrst");
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(1'b1, 10'(k), 1'b0);
      check($sformatf("refill_ovalid_%0d", k), 64'(bus.out_valid), 0);
    end
    drive(1'b0, 10'sd0, 1'b0);
    check("refill_ovalid", 64'(bus.out_valid), 1);
    check("refill_ps0", ps(0), 6);
    check("refill_centre", bus.centre, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_tap_delay_line.md
# fir_tap_delay_line

Parametrised, enable-gated tap delay line for the symmetric FIR datapath: shifts signed samples through DEPTH registers, exposes every tap, and produces registered symmetric pre-add sums (tap[i] + tap[DEPTH-1-i]) plus the centre tap for the multiplier stage. It replaces fixed-width per-tap flip-flops with one block carrying a fill counter, flush, and valid tracking so downstream logic never consumes taps from a partially filled line.

## Interface
- WIDTH, 10, sample width in bits (signed two's complement), ≥2
- DEPTH, 5, number of taps, odd, 3..31
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; rst=0 at a clk edge clears all state
- in_valid  in  1  sample strobe; shift occurs only on cycles with in_valid=1
- in_data  in  WIDTH  signed input sample
- flush  in  1  synchronous clear of taps and fill count without full reset
- taps  out  DEPTH*WIDTH  flattened tap registers, tap[0] (newest) at LSBs
- fill_count  out  $clog2(DEPTH+1)  samples held since reset/flush, saturates at DEPTH
- full  out  1  fill_count == DEPTH
- pair_sum  out  (DEPTH/2)*(WIDTH+1)  registered tap[i]+tap[DEPTH-1-i], i=0 at LSBs
- centre  out  WIDTH  registered tap[DEPTH/2]
- out_valid  out  1  one-cycle pulse: pair_sum/centre computed from a full line

## Operation
- Reset (rst=0): taps, fill_count, pair_sum, centre, out_valid all 0; full=0. Reset overrides flush and in_valid.
- Shift (in_valid=1, flush=0): tap[0]<=in_data, tap[k]<=tap[k-1]; fill_count increments, saturating at DEPTH.
- Hold (in_valid=0, flush=0): taps and fill_count unchanged; pair_sum/centre hold; out_valid=0.
- Flush (flush=1): taps cleared; fill_count<=0. If in_valid=1 in the same cycle, the sample is loaded after the clear: tap[0]<=in_data, others 0, fill_count<=1. out_valid<=0 in the flush cycle.
- Pre-add stage: on each cycle, if a shift occurred in the previous cycle, pair_sum and centre register values from current taps; out_valid<=full (line was full after that shift). Otherwise pair_sum/centre hold and out_valid<=0.
- Width: pair_sum entries sign-extended to WIDTH+1 before add; no overflow or saturation possible. centre is not extended.
- fill_count is a saturating counter; no wrap.

## Timing
- in_data sampled at edge n (in_valid=1) appears on tap[0] after edge n.
- pair_sum/centre/out_valid reflecting that shift update after edge n+1: total latency 2 cycles input-to-sum.
- full asserts combinationally from fill_count, i.e. after the DEPTH-th shift edge.
- First out_valid pulse: 2 cycles after the DEPTH-th accepted sample since reset/flush.
- Back-to-back in_valid: one out_valid pulse per accepted sample once full; throughput 1 sample/cycle.
- Flush at edge n cancels any out_valid due at edge n+1 (out_valid forced 0 at n+1 as well, since line no longer full).
- Reset mid-operation: all outputs 0 after the edge; in-flight sums discarded.

## Structure
- Shared package fir_pkg: default WIDTH/DEPTH constants, sum-width function (WIDTH+1), fill-count width function ($clog2(DEPTH+1)).
- Sub-module fir_tap_reg: single WIDTH-bit signed register with enable, sync clear and sync active-low rst; instantiated DEPTH times in a generate loop.
- Pre-add and fill counter stay in the top module.

## Test plan
- Reset: drive samples with rst=0 for 3 cycles -> all taps, pair_sum, centre, fill_count, out_valid = 0.
- Fill DEPTH=5, WIDTH=10: feed 1,2,3,4,5 back-to-back -> full after 5th edge; 2 cycles after 5th sample pair_sum[0]=6, pair_sum[1]=6, centre=3, out_valid=1 for one cycle.
- Extremes: feed -512 ×5 then 511 ×5 -> pair_sum[0]=-1024 then 1022 with no wrap; mixed -512/511 gives -1.
- Gaps: in_valid toggled 1,0,0,1 -> taps and sums hold on idle cycles; out_valid only on cycles following a shift once full.
- Flush with in_valid=1 on full line carrying 7 -> tap[0]=7, others 0, fill_count=1, full=0, no out_valid until 4 further samples accepted.
- Reset mid-stream after 3 samples -> all outputs 0 next cycle; refill requires 5 new samples before out_valid.
